// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment codes,
// blanked-output value and a constant-evaluable ceil(log2) helper.
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'h00;

   // Index 0 is the rightmost entry; bit 7 = a ... bit 1 = g, bit 0 (dp) left clear.
   localparam logic [15:0][7:0] SEG_LUT = {
      8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
   };

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to a..g segment pattern, purely combinational.
module seg7_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_LUT[nib_i][7:1];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner with frame-synchronous double-buffered content,
// per-digit dp/blank/blink and PWM dimming.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_DIV    = 100000,
   parameter int BLINK_DIV  = 250,
   parameter int DUTY_W     = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] content,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [NUM_DIGITS-1:0]   blink_in,
   input  logic                    load,
   input  logic [DUTY_W-1:0]       brightness,
   output logic [NUM_DIGITS-1:0]   seg_en,
   output logic [7:0]              seg_out,
   output logic                    frame_start
);

   localparam int IDX_W = clog2(NUM_DIGITS);
   localparam int PS_W  = clog2(CLK_DIV);
   localparam int BL_W  = (BLINK_DIV > 1) ? clog2(BLINK_DIV) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(CLK_DIV - 1);
   localparam logic [BL_W-1:0]  BL_MAX  = BL_W'(BLINK_DIV - 1);

   logic [PS_W-1:0]             ps_q, ps_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [DUTY_W-1:0]           pwm_q, pwm_d;
   logic [BL_W-1:0]             bcnt_q, bcnt_d;
   logic                        bph_q, bph_d;
   logic [NUM_DIGITS-1:0][3:0]  stage_q, stage_d;
   logic [NUM_DIGITS-1:0][3:0]  act_q, act_d;
   logic                        pend_q, pend_d;
   logic [NUM_DIGITS-1:0]       seg_en_q, seg_en_d;
   logic [7:0]                  seg_out_q, seg_out_d;
   logic                        fs_q, fs_d;
   logic                        tick, wrap, vis;
   logic [6:0]                  dec;

   seg7_hex_decode u_dec (
      .nib_i (act_q[idx_q]),
      .seg_o (dec)
   );

   always_comb begin
      tick   = (ps_q == PS_MAX);
      wrap   = tick && (idx_q == IDX_MAX);
      ps_d   = tick ? '0 : ps_q + 1'b1;
      idx_d  = idx_q;
      if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      pwm_d  = pwm_q + 1'b1;

      bcnt_d = bcnt_q;
      bph_d  = bph_q;
      if (wrap) begin
         if (bcnt_q == BL_MAX) begin
            bcnt_d = '0;
            bph_d  = ~bph_q;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end

      stage_d = stage_q;
      act_d   = act_q;
      pend_d  = pend_q;
      if (load) begin
         stage_d = content;
         pend_d  = 1'b1;
      end
      // A load landing on the boundary tick goes straight to the active buffer.
      if (wrap) begin
         if (load) begin
            act_d  = content;
            pend_d = 1'b0;
         end else if (pend_q) begin
            act_d  = stage_q;
            pend_d = 1'b0;
         end
      end

      vis = en && !blank_in[idx_q] && !(blink_in[idx_q] && bph_q)
            && (pwm_q <= brightness);
      seg_en_d  = '0;
      seg_out_d = SEG_OFF;
      if (vis) begin
         seg_en_d[idx_q] = 1'b1;
         seg_out_d       = {dec, dp_in[idx_q]};
      end
      fs_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ps_q      <= '0;
         idx_q     <= '0;
         pwm_q     <= '0;
         bcnt_q    <= '0;
         bph_q     <= 1'b0;
         stage_q   <= '0;
         act_q     <= '0;
         pend_q    <= 1'b0;
         seg_en_q  <= '0;
         seg_out_q <= SEG_OFF;
         fs_q      <= 1'b0;
      end else begin
         ps_q      <= ps_d;
         idx_q     <= idx_d;
         pwm_q     <= pwm_d;
         bcnt_q    <= bcnt_d;
         bph_q     <= bph_d;
         stage_q   <= stage_d;
         act_q     <= act_d;
         pend_q    <= pend_d;
         seg_en_q  <= seg_en_d;
         seg_out_q <= seg_out_d;
         fs_q      <= fs_d;
      end
   end

   assign seg_en      = seg_en_q;
   assign seg_out     = seg_out_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, 4 clks per slot, 16-clk frames.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        load = 1'b0;
   logic [15:0] content = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic [3:0]  blink_in = '0;
   logic [1:0]  brightness = 2'd3;
   logic [3:0]  seg_en;
   logic [7:0]  seg_out;
   logic        frame_start;
   int          n = 0;
   int          checks = 0;
   int          errors = 0;

   seg_scan_ctrl #(
      .NUM_DIGITS (4),
      .CLK_DIV    (4),
      .BLINK_DIV  (2),
      .DUTY_W     (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .content     (content),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .blink_in    (blink_in),
      .load        (load),
      .brightness  (brightness),
      .seg_en      (seg_en),
      .seg_out     (seg_out),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   // One aligned 16-clk frame. exp = {d3,d2,d1,d0} segment bytes, mask = digits
   // expected lit; la/lb are slot offsets at which load is pulsed (-1 = none).
   task automatic run_frame(input string tag, input logic [31:0] exp, input logic [3:0] mask,
                            input int la, input logic [15:0] va,
                            input int lb, input logic [15:0] vb);
      for (int i = 0; i < 16; i++) begin
         int   d;
         logic v;
         d    = i / 4;
         load = (i == la) || (i == lb);
         if (i == la) content = va;
         if (i == lb) content = vb;
         step();
         load = 1'b0;
         v = mask[d] && ((i % 4) <= int'(brightness));
         chk($sformatf("%s.en%0d", tag, i), seg_en, v ? (32'd1 << d) : 32'd0);
         chk($sformatf("%s.seg%0d", tag, i), seg_out, v ? exp[8*d +: 8] : 32'h00);
         chk($sformatf("%s.fs%0d", tag, i), frame_start, (i == 15) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      repeat (3) step();
      chk("rst.en", seg_en, 0);
      chk("rst.seg", seg_out, 0);
      chk("rst.fs", frame_start, 0);
      rst = 1'b0;
      n = 0;

      run_frame("f0", {4{8'hFC}}, 4'hF, -1, 16'h0, -1, 16'h0);
      run_frame("f1", {4{8'hFC}}, 4'hF, -1, 16'h0, -1, 16'h0);
      run_frame("f2", {4{8'hFC}}, 4'hF, 6, 16'h8A10, -1, 16'h0);
      run_frame("f3", {8'hFE, 8'hEE, 8'h60, 8'hFC}, 4'hF, -1, 16'h0, -1, 16'h0);
      run_frame("f4", {8'hFE, 8'hEE, 8'h60, 8'hFC}, 4'hF, 2, 16'h1111, 6, 16'h2222);
      run_frame("f5", {4{8'hDA}}, 4'hF, 15, 16'h3333, -1, 16'h0);
      run_frame("f6", {4{8'hF2}}, 4'hF, 3, 16'h0010, -1, 16'h0);

      dp_in = 4'b0010;
      blank_in = 4'b0100;
      run_frame("f7", {8'hFC, 8'h00, 8'h61, 8'hFC}, 4'b1011, -1, 16'h0, -1, 16'h0);
      dp_in = '0;
      blank_in = '0;

      blink_in = 4'b0001;
      run_frame("b0", {8'hFC, 8'hFC, 8'h60, 8'hFC}, 4'b1111, -1, 16'h0, -1, 16'h0);
      run_frame("b1", {8'hFC, 8'hFC, 8'h60, 8'hFC}, 4'b1111, -1, 16'h0, -1, 16'h0);
      run_frame("b2", {8'hFC, 8'hFC, 8'h60, 8'hFC}, 4'b1110, -1, 16'h0, -1, 16'h0);
      run_frame("b3", {8'hFC, 8'hFC, 8'h60, 8'hFC}, 4'b1110, -1, 16'h0, -1, 16'h0);
      run_frame("b4", {8'hFC, 8'hFC, 8'h60, 8'hFC}, 4'b1111, -1, 16'h0, -1, 16'h0);
      run_frame("b5", {8'hFC, 8'hFC, 8'h60, 8'hFC}, 4'b1111, -1, 16'h0, -1, 16'h0);
      blink_in = '0;

      brightness = 2'd1;
      run_frame("pwm", {8'hFC, 8'hFC, 8'h60, 8'hFC}, 4'b1111, -1, 16'h0, -1, 16'h0);
      brightness = 2'd3;

      // Leave a load pending, then reset mid-slot: it must not survive.
      load = 1'b1;
      content = 16'hFFFF;
      step();
      load = 1'b0;
      repeat (4) step();
      chk("pre_rst.en", seg_en, 4'b0010);
      rst = 1'b1;
      step();
      chk("mid_rst.en", seg_en, 0);
      chk("mid_rst.seg", seg_out, 0);
      chk("mid_rst.fs", frame_start, 0);
      step();
      rst = 1'b0;
      n = 0;
      run_frame("r0", {4{8'hFC}}, 4'hF, -1, 16'h0, -1, 16'h0);
      run_frame("r1", {4{8'hFC}}, 4'hF, -1, 16'h0, -1, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised multiplexed 7-segment display controller, the successor to the fixed 4-digit scanner. It drives NUM_DIGITS common-enable digits from a single fast system clock, using an internal scan prescaler instead of an external slow clock. New behaviour over the 4-digit scanner:
- frame-synchronous double-buffered content loading (no tearing)
- per-digit decimal point, blanking and blinking
- PWM brightness control
It sits between the application datapath (score/timer/menu logic) and the board segment pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned; 2..16.
CLK_DIV, 100000, clk cycles per digit slot; >= 2.
BLINK_DIV, 250, frames per blink half-period; >= 1.
DUTY_W, 3, brightness code width; PWM period is 2^DUTY_W clk cycles.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous reset, active-high.
en  in  1  display enable; 0 forces all digits dark, counters keep running.
content  in  4*NUM_DIGITS  hex nibble per digit; digit i = content[4i+3:4i].
dp_in  in  NUM_DIGITS  per-digit decimal point, sampled live.
blank_in  in  NUM_DIGITS  per-digit blank, sampled live.
blink_in  in  NUM_DIGITS  per-digit blink select, sampled live.
load  in  1  one-cycle strobe; captures content into the staging buffer.
brightness  in  DUTY_W  duty code; digit lit while pwm_cnt <= brightness.
seg_en  out  NUM_DIGITS  one-hot digit enable, active-high.
seg_out  out  8  segments, active-high: [7]=a … [1]=g, [0]=dp.
frame_start  out  1  one-cycle pulse when the active buffer commits (index wraps to 0).

Behaviour:
- Reset (rst=1 at a clk edge): prescaler, digit index, pwm_cnt, blink frame counter and blink_phase all go to 0. Staging buffer, active buffer and the pending flag all go to 0. seg_en=0, seg_out=0, frame_start=0. Any pending load is discarded.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick=1 while the count equals CLK_DIV-1.
- Digit index: on tick, advances by 1. It wraps from NUM_DIGITS-1 to 0; this wrap is the frame boundary.
- Load: on load=1, staging is set to content and pending is set to 1. A second load before commit overwrites staging (latest wins).
- Commit: at the frame-boundary tick, if pending=1, active is set to staging and pending is cleared.
- Load on the same cycle as the commit: the new content bypasses staging into active, and pending ends at 0.
- frame_start: pulses on every frame boundary, whether or not a commit occurs.
- Blink: a frame counter increments at each frame boundary. At BLINK_DIV-1 it wraps to 0 and toggles blink_phase.
- PWM: pwm_cnt is a DUTY_W-bit free-running counter, incremented every clk. An all-ones brightness code means always lit.
- Digit i = index is visible when en=1, blank_in[i]=0, !(blink_in[i] && blink_phase), and pwm_cnt <= brightness.
- Outputs: seg_en and seg_out are registered, one clk after index/pwm_cnt.
  - Visible: seg_en = one-hot(index); seg_out = {decode(active nibble), dp_in[index]}.
  - Not visible: seg_en=0 and seg_out=8'h00.
- Decode (a..g), hex digits:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0
  - 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
  - These values are with dp=0; dp adds 1.
- Width rule: index width is clog2(NUM_DIGITS). Index values >= NUM_DIGITS never occur.
- Dimming must never enable two digits at once. At most one seg_en bit is high in any cycle.

Decomposition:
- Shared package seg_pkg holds:
  - the 16-entry segment code constants
  - the SEG_OFF=8'h00 constant
  - the clog2 helper function
- One sub-module: seg7_hex_decode (4-bit nibble in, 7-bit a..g out, combinational). It is instantiated once, on the muxed nibble.

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=4, BLINK_DIV=2, DUTY_W=2, brightness=3, en=1 unless stated.
- Reset then release: seg_en=0000, seg_out=00 during reset. After release, seg_en rotates 0001→0010→0100→1000→0001, 4 clks each, and frame_start pulses every 16 clks.
- Load 16'h8A10 mid-frame: the display is unchanged until the next frame_start. From then on, digit0=FC, digit1=60, digit2=EE, digit3=FE.
- Two loads in one frame (16'h1111 then 16'h2222), plus a load on the commit cycle: the next frame shows only the latest value. The commit-cycle load appears in the frame that starts at that commit.
- dp_in=0010, blank_in=0100: the digit1 slot shows 61. seg_en[2] is never asserted, and seg_out=00 during the slot-2 window.
- blink_in=0001: digit0 is lit in frames 0-1, dark (seg_en[0]=0) in frames 2-3, and lit again in frames 4-5.
- brightness=1: within each slot seg_en is high 2 of every 4 clks (pwm_cnt 0,1). Then assert rst mid-slot: next edge seg_en=0 and the pending load is lost.
